cpu_ctl: RTL and testbench
==========================

Name: cpu_ctl

Overview:
- Instruction-sequencing controller for the RISC CPU core.
- Consumes the `fetch` and `alu_ena` timing strobes from the core clock generator, which run on an 8-cycle period.
- Runs an 8-state per-instruction sequence locked to those strobes and decodes the 3-bit opcode plus the accumulator zero flag into datapath strobes: PC, IR, ACC, memory read/write, data-bus drive, halt.
- Flags loss of lock with the clock generator.

Parameters:
- OPW, 3, opcode width. Encodings fixed: HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7.
- ALU_STATE, 5, sequence state in which `alu_ena` must be high.
- SYNC_STATE, 7, sequence state in which the `fetch` rising edge must be sampled.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- fetch  in  1  clock-generator fetch strobe (high 4 of every 8 cycles)
- alu_ena  in  1  clock-generator ALU strobe (high 1 of every 8 cycles, 2 cycles before fetch rises)
- opcode  in  OPW  IR opcode field, valid from state 2 onward
- zero  in  1  accumulator == 0
- inc_pc  out  1  increment PC
- load_ir  out  1  load IR byte
- rd  out  1  memory read
- wr  out  1  memory write
- load_acc  out  1  load accumulator from ALU
- load_pc  out  1  load PC from IR address
- datactl_ena  out  1  drive ACC onto data bus
- halt  out  1  CPU halted (sticky)
- sync_err  out  1  one-cycle pulse on strobe misalignment

Behaviour:
- Reset is asynchronous.
  - Cleared on reset: state=0, run=0, halt=0, fetch_d=0, sync_err=0.
  - With run=0, all strobe outputs are 0.
- fetch_d is a registered copy of fetch. rise = fetch & ~fetch_d.
- Start:
  - While run=0 and halt=0, the first clock edge sampling rise=1 sets run=1 and state=0.
  - State 0 occupies the following cycle.
- Sequencing:
  - While run=1, state advances 0→1→…→7→0, one step per clock.
  - If rise is sampled with run=1 and state≠SYNC_STATE: state is forced to 0 (resync) and sync_err is registered high for one cycle.
  - If alu_ena is sampled high with run=1 and state≠ALU_STATE: sync_err is registered high for one cycle; state is unaffected.
  - A correctly aligned stream never raises sync_err.
- Strobe decode:
  - Strobes are combinational from (state, opcode, zero). They are valid for the whole cycle the state is held.
  - All strobes are 0 unless run=1 and halt=0.
  - S0: load_ir, rd, inc_pc (opcode/high byte).
  - S1: load_ir, rd, inc_pc (address/low byte).
  - S2: none.
  - S3: none. If opcode=HLT, the edge leaving S3 sets halt=1 and run=0.
  - S4:
    - ADD/ANDD/XORR/LDA: rd.
    - STO: datactl_ena.
    - JMP: load_pc.
    - SKZ with zero=1: inc_pc.
  - S5:
    - ADD/ANDD/XORR/LDA: rd, load_acc.
    - STO: datactl_ena, wr.
    - SKZ with zero=1: inc_pc (2-byte skip).
  - S6: STO: datactl_ena.
  - S7: none.
  - wr is never asserted without datactl_ena. rd and wr are never high together.
  - opcode and zero are sampled combinationally each cycle. zero changing mid-SKZ affects only the cycle in which it is observed.
- Halt:
  - halt is sticky until reset. While halted, fetch and alu_ena are ignored and sync_err stays 0.
- Reset mid-instruction: all strobes drop asynchronously. A restart requires a new fetch rise.

Test Plan:
- Reset, then 3 periods of a correctly aligned fetch/alu_ena stream with opcode=ADD.
  - State 0 begins the cycle after the first fetch rise.
  - rd in S0, S1, S4, S5; load_ir and inc_pc in S0–S1; load_acc only in S5, coinciding with alu_ena.
  - sync_err stays 0.
- STO instruction:
  - datactl_ena high in S4, S5, S6.
  - wr high only in S5.
  - rd low in S4–S6.
- SKZ with zero=1: inc_pc high in S0, S1, S4, S5 (4 cycles). Repeat with zero=0: inc_pc high in S0, S1 only. JMP: load_pc high only in S4.
- HLT in the second instruction:
  - halt rises at the edge leaving S3 and remains high through 5 further periods.
  - All strobes stay 0.
  - Asserting reset clears halt immediately, without waiting for a clock edge.
- Misalignment:
  - Inject an extra fetch rise while in state 3 → sync_err pulses once, and state is 0 on the next cycle.
  - Inject alu_ena high in state 2 → sync_err pulses once, and the sequence continues without resync.
- Assert reset in S5 of an ADD → load_acc and rd drop immediately. After release, no strobe until the next fetch rise.

Source files
------------

// File: rtl/cpu_ctl.sv
// cpu_ctl: per-instruction sequencing controller for the RISC core.
// An 8-state sequence is locked to the clock generator's fetch/alu_ena
// strobes. Datapath strobes are decoded combinationally from the state,
// opcode and the accumulator zero flag. Strobe misalignment is reported
// on sync_err and a HLT opcode parks the core until reset.
module cpu_ctl #(
    parameter int OPW        = 3,
    parameter int ALU_STATE  = 5,
    parameter int SYNC_STATE = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           fetch,
    input  logic           alu_ena,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output logic           inc_pc,
    output logic           load_ir,
    output logic           rd,
    output logic           wr,
    output logic           load_acc,
    output logic           load_pc,
    output logic           datactl_ena,
    output logic           halt,
    output logic           sync_err
);

    // Sequence states
    localparam logic [2:0] S0 = 3'd0;
    localparam logic [2:0] S1 = 3'd1;
    localparam logic [2:0] S2 = 3'd2;
    localparam logic [2:0] S3 = 3'd3;
    localparam logic [2:0] S4 = 3'd4;
    localparam logic [2:0] S5 = 3'd5;
    localparam logic [2:0] S6 = 3'd6;
    localparam logic [2:0] S7 = 3'd7;

    // States in which the clock-generator strobes are expected
    localparam logic [2:0] ALU_ST  = 3'(ALU_STATE);
    localparam logic [2:0] SYNC_ST = 3'(SYNC_STATE);

    // Opcode encodings
    localparam logic [OPW-1:0] OP_HLT  = OPW'(3'd0);
    localparam logic [OPW-1:0] OP_SKZ  = OPW'(3'd1);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3'd2);
    localparam logic [OPW-1:0] OP_ANDD = OPW'(3'd3);
    localparam logic [OPW-1:0] OP_XORR = OPW'(3'd4);
    localparam logic [OPW-1:0] OP_LDA  = OPW'(3'd5);
    localparam logic [OPW-1:0] OP_STO  = OPW'(3'd6);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(3'd7);

    logic [2:0] state_r;
    logic [2:0] state_s;
    logic       run_r;
    logic       run_s;
    logic       halt_r;
    logic       halt_s;
    logic       fetch_d_r;
    logic       sync_err_r;
    logic       sync_err_s;

    logic       rise_s;
    logic       active_s;
    logic       rise_err_s;
    logic       alu_err_s;

    logic       inc_pc_s;
    logic       load_ir_s;
    logic       rd_s;
    logic       wr_s;
    logic       load_acc_s;
    logic       load_pc_s;
    logic       datactl_s;

    assign rise_s     = fetch & ~fetch_d_r;
    assign active_s   = run_r & ~halt_r;
    // Misalignment is only meaningful while the sequence is running
    assign rise_err_s = active_s & rise_s & (state_r != SYNC_ST);
    assign alu_err_s  = active_s & alu_ena & (state_r != ALU_ST);

    // Next-state logic: start on first fetch rise, step, resync, halt
    always_comb begin
        state_s    = state_r;
        run_s      = run_r;
        halt_s     = halt_r;
        sync_err_s = 1'b0;
        if (halt_r) begin
            // Parked: strobes from the clock generator are ignored
            state_s = S0;
            run_s   = 1'b0;
        end else if (!run_r) begin
            if (rise_s) begin
                run_s   = 1'b1;
                state_s = S0;
            end else begin
                state_s = state_r;
            end
        end else begin
            // A fetch rise outside SYNC_ST restarts the sequence; it takes
            // priority over HLT because the opcode can no longer be trusted.
            if (rise_err_s) begin
                state_s = S0;
            end else if ((state_r == S3) && (opcode == OP_HLT)) begin
                halt_s  = 1'b1;
                run_s   = 1'b0;
                state_s = S0;
            end else begin
                state_s = state_r + 3'd1;
            end
            sync_err_s = rise_err_s | alu_err_s;
        end
    end

    // Sequence state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S0;
            run_r      <= 1'b0;
            halt_r     <= 1'b0;
            fetch_d_r  <= 1'b0;
            sync_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            run_r      <= run_s;
            halt_r     <= halt_s;
            fetch_d_r  <= fetch;
            sync_err_r <= sync_err_s;
        end
    end

    // Datapath strobe decode from state, opcode and zero flag
    always_comb begin
        inc_pc_s   = 1'b0;
        load_ir_s  = 1'b0;
        rd_s       = 1'b0;
        wr_s       = 1'b0;
        load_acc_s = 1'b0;
        load_pc_s  = 1'b0;
        datactl_s  = 1'b0;
        if (active_s) begin
            case (state_r)
                S0, S1: begin
                    // Fetch opcode byte, then address byte
                    load_ir_s = 1'b1;
                    rd_s      = 1'b1;
                    inc_pc_s  = 1'b1;
                end
                S4: begin
                    case (opcode)
                        OP_ADD, OP_ANDD, OP_XORR, OP_LDA: rd_s      = 1'b1;
                        OP_STO:                           datactl_s = 1'b1;
                        OP_JMP:                           load_pc_s = 1'b1;
                        OP_SKZ:                           inc_pc_s  = zero;
                        default:                          rd_s      = 1'b0;
                    endcase
                end
                S5: begin
                    case (opcode)
                        OP_ADD, OP_ANDD, OP_XORR, OP_LDA: begin
                            rd_s       = 1'b1;
                            load_acc_s = 1'b1;
                        end
                        OP_STO: begin
                            datactl_s = 1'b1;
                            wr_s      = 1'b1;
                        end
                        // Second PC bump completes the two-byte skip
                        OP_SKZ:  inc_pc_s = zero;
                        default: rd_s     = 1'b0;
                    endcase
                end
                S6: begin
                    if (opcode == OP_STO) begin
                        datactl_s = 1'b1;
                    end else begin
                        datactl_s = 1'b0;
                    end
                end
                S2, S3, S7: begin
                    rd_s = 1'b0;
                end
                default: begin
                    rd_s = 1'b0;
                end
            endcase
        end else begin
            rd_s = 1'b0;
        end
    end

    // Strobes stay combinational so an asynchronous reset drops them at once
    assign inc_pc      = inc_pc_s;
    assign load_ir     = load_ir_s;
    assign rd          = rd_s;
    assign wr          = wr_s;
    assign load_acc    = load_acc_s;
    assign load_pc     = load_pc_s;
    assign datactl_ena = datactl_s;
    assign halt        = halt_r;
    assign sync_err    = sync_err_r;

endmodule

// File: tb/tb_cpu_ctl.sv
// Scoreboard bench for cpu_ctl. A driver issues one cycle of stimulus at a
// time and pushes the expected output vector from an instruction-level
// reference model; a monitor pops and compares on every falling edge (or
// on demand after a mid-cycle reset).
module tb_cpu_ctl;

    logic       clk;
    logic       reset;
    logic       fetch;
    logic       alu_ena;
    logic [2:0] opcode;
    logic       zero;
    logic       inc_pc;
    logic       load_ir;
    logic       rd;
    logic       wr;
    logic       load_acc;
    logic       load_pc;
    logic       datactl_ena;
    logic       halt;
    logic       sync_err;

    cpu_ctl dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .alu_ena     (alu_ena),
        .opcode      (opcode),
        .zero        (zero),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .load_acc    (load_acc),
        .load_pc     (load_pc),
        .datactl_ena (datactl_ena),
        .halt        (halt),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard
    logic [8:0] exp_q[$];
    event       mid_ev;
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model: instruction progress, not RTL state encoding
    bit         m_run, m_halt, m_fd, m_err;
    int         m_step;
    // Inputs applied during the cycle now ending
    bit         p_fetch, p_alu, p_rst;
    logic [2:0] p_op;
    bit         p_zero;

    task automatic model_clear();
        m_run  = 1'b0;
        m_halt = 1'b0;
        m_fd   = 1'b0;
        m_err  = 1'b0;
        m_step = 0;
    endtask

    // Advance the model over one rising clock edge
    task automatic model_edge();
        bit rise;
        bit err;
        int old_step;
        if (p_rst) begin
            model_clear();
        end else begin
            rise     = p_fetch && !m_fd;
            err      = 1'b0;
            old_step = m_step;
            if (m_halt) begin
                err = 1'b0;
            end else if (!m_run) begin
                if (rise) begin
                    m_run  = 1'b1;
                    m_step = 0;
                end
            end else begin
                if (rise && old_step != 7) begin
                    m_step = 0;
                    err    = 1'b1;
                end else if (old_step == 3 && p_op == 3'd0) begin
                    m_halt = 1'b1;
                    m_run  = 1'b0;
                    m_step = 0;
                end else begin
                    m_step = (old_step + 1) % 8;
                end
                if (p_alu && old_step != 5) err = 1'b1;
            end
            m_fd  = p_fetch;
            m_err = err;
        end
    endtask

    // Expected {inc_pc,load_ir,rd,wr,load_acc,load_pc,datactl_ena,halt,sync_err}
    function automatic logic [8:0] expect_vec(logic [2:0] op, bit z);
        bit act, mem_op, fetch_phase;
        bit e_inc, e_ir, e_rd, e_wr, e_acc, e_pc, e_dc;
        act         = m_run && !m_halt;
        mem_op      = op inside {3'd2, 3'd3, 3'd4, 3'd5};
        fetch_phase = m_step inside {0, 1};
        e_inc = act && (fetch_phase || (op == 3'd1 && z && m_step inside {4, 5}));
        e_ir  = act && fetch_phase;
        e_rd  = act && (fetch_phase || (mem_op && m_step inside {4, 5}));
        e_wr  = act && op == 3'd6 && m_step == 5;
        e_acc = act && mem_op && m_step == 5;
        e_pc  = act && op == 3'd7 && m_step == 4;
        e_dc  = act && op == 3'd6 && m_step inside {4, 5, 6};
        return {e_inc, e_ir, e_rd, e_wr, e_acc, e_pc, e_dc, m_halt, m_err};
    endfunction

    // Drive one clock cycle of inputs and push what the DUT should show
    task automatic step(input bit f, input bit a, input logic [2:0] op,
                        input bit z, input bit r);
        @(posedge clk);
        #1;
        model_edge();
        fetch   = f;
        alu_ena = a;
        opcode  = op;
        zero    = z;
        reset   = r;
        p_fetch = f;
        p_alu   = a;
        p_op    = op;
        p_zero  = z;
        p_rst   = r;
        if (r) model_clear();
        exp_q.push_back(expect_vec(op, z));
    endtask

    // Assert reset in the middle of the current cycle and check at once
    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset = 1'b1;
        p_rst = 1'b1;
        model_clear();
        exp_q.push_back(expect_vec(opcode, zero));
        #1;
        ->mid_ev;
    endtask

    // One strobe period, starting with the fetch-rise cycle.
    // zmode: 0/1 fixed zero, 2 random per cycle.
    // inj: 0 clean, 1 extra fetch rise in S3, 2 alu_ena in S2, 3 random glitches.
    task automatic period(input logic [2:0] op, input int zmode,
                          input int inj, input int ncyc);
        int         ph;
        bit         f, a, z;
        logic [2:0] o;
        for (int i = 0; i < ncyc; i++) begin
            ph = (i + 7) % 8;
            f  = ph inside {7, 0, 1, 2};
            a  = (ph == 5);
            if (inj == 1 && ph == 2) f = 1'b0;
            if (inj == 1 && ph == 3) f = 1'b1;
            if (inj == 2 && ph == 2) a = 1'b1;
            if (inj == 3 && $urandom_range(0, 19) == 0) f = ~f;
            if (inj == 3 && $urandom_range(0, 19) == 0) a = ~a;
            o = op;
            if ((inj == 0 || inj == 3) && ph inside {7, 0, 1})
                o = 3'($urandom_range(0, 7));
            z = (zmode == 2) ? bit'($urandom_range(0, 1)) : bit'(zmode);
            step(f, a, o, z, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit rand_alu);
        for (int i = 0; i < n; i++)
            step(1'b0, rand_alu ? bit'($urandom_range(0, 1)) : 1'b0,
                 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)), 1'b0);
    endtask

    // Monitor: compare DUT outputs against the scoreboard head
    initial begin
        logic [8:0] exp_v;
        logic [8:0] act_v;
        forever begin
            @(negedge clk or mid_ev);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {inc_pc, load_ir, rd, wr, load_acc, load_pc,
                         datactl_ena, halt, sync_err};
                vectors++;
                if (act_v !== exp_v) begin
                    miscompares++;
                    $display("FAIL strobes vec=%0d t=%0t: got %b expected %b (inc_pc,load_ir,rd,wr,load_acc,load_pc,datactl,halt,sync_err)",
                             vectors, $time, act_v, exp_v);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [2:0] rop;
        reset   = 1'b1;
        fetch   = 1'b0;
        alu_ena = 1'b0;
        opcode  = 3'd0;
        zero    = 1'b0;
        p_fetch = 1'b0;
        p_alu   = 1'b0;
        p_op    = 3'd0;
        p_zero  = 1'b0;
        p_rst   = 1'b1;
        model_clear();

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Aligned ADD stream
        for (int i = 0; i < 3; i++) period(3'd2, 2, 0, 8);
        // Instruction mix
        period(3'd6, 2, 0, 8);   // STO
        period(3'd1, 1, 0, 8);   // SKZ, zero set
        period(3'd1, 0, 0, 8);   // SKZ, zero clear
        period(3'd1, 2, 0, 8);   // SKZ, zero toggling
        period(3'd7, 2, 0, 8);   // JMP
        period(3'd5, 2, 0, 8);   // LDA
        period(3'd3, 2, 0, 8);   // ANDD
        period(3'd4, 2, 0, 8);   // XORR

        // Misalignment: extra fetch rise in S3, then stray alu_ena in S2
        period(3'd2, 2, 1, 8);
        period(3'd2, 2, 0, 8);
        period(3'd2, 2, 2, 8);
        period(3'd2, 2, 0, 8);

        // Reset in S5 of an ADD, then no strobes until a new fetch rise
        period(3'd2, 2, 0, 7);
        reset_mid();
        step(1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
        idle(5, 1'b1);
        period(3'd2, 2, 0, 8);

        // HLT as second instruction, then five more periods while halted
        reset_mid();
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        idle(2, 1'b0);
        period(3'd2, 2, 0, 8);
        period(3'd0, 2, 0, 8);
        for (int i = 0; i < 5; i++) period(3'($urandom_range(0, 7)), 2, 3, 8);
        reset_mid();
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        idle(2, 1'b0);

        // Randomized instruction stream with occasional glitches
        for (int i = 0; i < 40; i++) begin
            rop = ($urandom_range(0, 11) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            period(rop, 2, ($urandom_range(0, 3) == 0) ? 3 : 0, 8);
            if (m_halt) begin
                period(3'($urandom_range(0, 7)), 2, 3, 8);
                step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
                idle(2, 1'b1);
            end
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
